product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 24: accumulator width in bits, legal range 16..32.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: a product beat is present.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a beat.
REQ-006 SHALL have port product, input, 16 bits: unsigned 8x8 multiplier result p[15:0].
REQ-007 SHALL have port in_last, input, 1 bit: marks the final beat of a group; qualified by in_valid.
REQ-008 SHALL have port out_valid, output, 1 bit: the group result is available.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 SHALL have port acc_out, output, ACC_W bits: group sum.
REQ-011 SHALL have port beat_cnt, output, 8 bits: number of beats accepted in the group.
REQ-012 SHALL have port ovf, output, 1 bit: sticky flag, set when the group sum exceeded 2^ACC_W-1.

Function
REQ-013 SHALL implement three states: IDLE, ACCUM and DONE.
REQ-014 SHALL treat a beat as accepted only in a cycle where in_valid and in_ready are both 1; in_valid with in_ready=0 has no effect.
REQ-015 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in DONE.
REQ-016 SHALL, on a beat accepted in IDLE, load acc = zero-extended product, set beat_cnt=1 and ovf=0, then go to DONE if in_last=1, else to ACCUM.
REQ-017 SHALL, on a beat accepted in ACCUM, set acc = acc + product (computed ACC_W+1 wide) and beat_cnt = beat_cnt+1 (wraps 255->0), then go to DONE if in_last=1.
REQ-018 SHALL set ovf in ACCUM when bit ACC_W of the sum is 1; ovf stays set until the next group starts.
REQ-019 SHALL assert out_valid exactly in DONE, starting the cycle after the in_last beat is accepted: 1-cycle latency.
REQ-020 SHALL hold acc_out, beat_cnt and ovf stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, on out_valid and out_ready both 1, return to IDLE on the next edge; no beat is accepted in that same cycle.
REQ-022 SHALL keep acc_out, beat_cnt and ovf at their last values in IDLE until the next accepted beat.
REQ-023 SHALL ignore product and in_last in any cycle without an accepted beat.

Reset
REQ-024 SHALL, while rst_n=0, force state=IDLE, acc_out=0, beat_cnt=0, ovf=0 and out_valid=0, independent of clk.
REQ-025 SHALL drive in_ready=1 during reset; a beat presented while rst_n=0 is not accepted.
REQ-026 SHALL discard any partial group when reset asserts mid-group; no out_valid is produced for that group.

Configuration
REQ-027 SHALL, with macro PRODUCT_ACC_SATURATE_EN defined, clamp acc to 2^ACC_W-1 on overflow and hold it there for the rest of the group; ovf is still set.
REQ-028 SHALL, without PRODUCT_ACC_SATURATE_EN, wrap acc modulo 2^ACC_W on overflow; ovf is still set.

Verification
REQ-029 SHALL cover a single beat: product=0xFE01 with in_last=1 -> next cycle out_valid=1, acc_out=0x00FE01, beat_cnt=1, ovf=0.
REQ-030 SHALL cover a four-beat group: beats 0x0001, 0x0010, 0x0100, 0x1000 (last) -> acc_out=0x001111, beat_cnt=4.
REQ-031 SHALL cover ACC_W=16 with two beats of 0xFE01 -> without macro acc_out=0xFC02, ovf=1; with macro acc_out=0xFFFF, ovf=1.
REQ-032 SHALL cover backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs stable, no beat absorbed; out_ready=1 -> IDLE next cycle.
REQ-033 SHALL cover reset mid-group: rst_n pulsed low after 2 of 3 beats -> out_valid=0, acc_out=0; next group of one beat 0x0005 -> acc_out=0x000005.
REQ-034 SHALL cover in_valid gaps: idle cycles between beats with random product values on the bus -> sum unaffected by non-accepted cycles.

Source files
------------

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//
// Sums a group of unsigned 16-bit multiplier products into an ACC_W-bit
// accumulator. It reports the sum, the beat count and a sticky overflow flag
// once the last beat of the group arrives.
//
// Parameters
//   ACC_W      accumulator width, legal range 16..32 (default 24)
//
// Build options
//   PRODUCT_ACC_SATURATE_EN  when defined, an overflowing accumulator is
//                            clamped to 2^ACC_W-1. When undefined, the
//                            accumulator wraps modulo 2^ACC_W. In both
//                            builds ovf is set.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a product beat is present on product/in_last
//   in_ready   block can take a beat (high in IDLE and ACCUM, and in reset)
//   product    unsigned 8x8 multiplier result
//   in_last    final beat of the group (qualified by in_valid)
//   out_valid  group result is available (exactly while in DONE)
//   out_ready  consumer takes the result
//   acc_out    group sum
//   beat_cnt   beats accepted in the group (wraps 255 -> 0)
//   ovf        sticky overflow flag for the current/last group
//   state_dbg  current FSM state encoding (IDLE=0, ACCUM=1, DONE=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Valid without ready has no effect, and payload is ignored when no
// transfer happens. On the input side, ready does not depend on valid. On the
// output side, acc_out/beat_cnt/ovf stay stable while out_valid=1 and
// out_ready=0. In the cycle the result is taken, in_ready is 0, so a new group
// can start at the earliest on the cycle after that.
// ---------------------------------------------------------------------------
module product_accumulator #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      product,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [7:0]       beat_cnt,
    output logic             ovf,
    output logic [1:0]       state_dbg
);

    localparam int SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state;
    logic             accept;
    logic [SUM_W-1:0] sum;
    logic             sum_carry;
    logic [ACC_W-1:0] acc_next;

    assign in_ready  = (state != S_DONE);
    assign out_valid = (state == S_DONE);
    assign state_dbg = state;
    assign accept    = in_valid && in_ready;

    // One extra bit holds the carry, so an overflow can be detected
    // before it is lost.
    assign sum       = {1'b0, acc_out} + SUM_W'(product);
    assign sum_carry = sum[ACC_W];

    always_comb begin
        acc_next = sum[ACC_W-1:0];
`ifdef PRODUCT_ACC_SATURATE_EN
        // Once at full scale, every further add carries again and stays
        // clamped, so the group keeps the maximum until it ends.
        if (sum_carry) begin
            acc_next = '1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            acc_out  <= '0;
            beat_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // The first beat starts a fresh group: load, do not add.
                    if (accept) begin
                        acc_out  <= ACC_W'(product);
                        beat_cnt <= 8'd1;
                        ovf      <= 1'b0;
                        state    <= in_last ? S_DONE : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        acc_out  <= acc_next;
                        beat_cnt <= beat_cnt + 8'd1;
                        if (sum_carry) begin
                            ovf <= 1'b1;
                        end
                        if (in_last) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Results stay held here and through IDLE until the
                    // next group's first beat.
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator
//
// Drives two instances (ACC_W=24 and ACC_W=16) from the same input stream.
// Every group result is therefore checked at both widths. The expected
// results for each group are queued when the group is driven, and they are
// popped when out_valid is seen.
// ---------------------------------------------------------------------------
module tb_product_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [15:0] product;

    logic        in_ready24, out_valid24, ovf24;
    logic [23:0] acc24;
    logic [7:0]  cnt24;
    logic [1:0]  st24;

    logic        in_ready16, out_valid16, ovf16;
    logic [15:0] acc16;
    logic [7:0]  cnt16;
    logic [1:0]  st16;

    int checks = 0;
    int errors = 0;

`ifdef PRODUCT_ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // scoreboard entry: {ovf, beat_cnt[7:0], acc[31:0]}
    logic [40:0] exp24_q[$];
    logic [40:0] exp16_q[$];

    typedef struct {
        logic [3:0][15:0] beats;
        int               n;
        logic [31:0]      acc24;
        logic [31:0]      acc16_wrap;
        logic [31:0]      acc16_sat;
        logic [7:0]       cnt;
        logic             ovf24;
        logic             ovf16;
    } vec_t;

    vec_t vecs[5];

    product_accumulator #(.ACC_W(24)) dut24 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready24),
        .product   (product),
        .in_last   (in_last),
        .out_valid (out_valid24),
        .out_ready (out_ready),
        .acc_out   (acc24),
        .beat_cnt  (cnt24),
        .ovf       (ovf24),
        .state_dbg (st24)
    );

    product_accumulator #(.ACC_W(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready16),
        .product   (product),
        .in_last   (in_last),
        .out_valid (out_valid16),
        .out_ready (out_ready),
        .acc_out   (acc16),
        .beat_cnt  (cnt16),
        .ovf       (ovf16),
        .state_dbg (st16)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a24, input logic [31:0] a16,
                            input logic [7:0] cnt, input logic o24, input logic o16);
        exp24_q.push_back({o24, cnt, a24});
        exp16_q.push_back({o16, cnt, a16});
    endtask

    // Present one beat. Both instances must be ready, so it is accepted on the
    // next edge. The bus is then filled with junk.
    task automatic send_beat(input logic [15:0] p, input logic last);
        check("in_ready24_beat", {31'd0, in_ready24}, 32'd1);
        check("in_ready16_beat", {31'd0, in_ready16}, 32'd1);
        in_valid = 1'b1;
        product  = p;
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        product  = 16'($urandom_range(0, 65535));
        in_last  = 1'($urandom_range(0, 1));
    endtask

    task automatic junk_cycles(input int n);
        repeat (n) begin
            in_valid = 1'b0;
            product  = 16'($urandom_range(0, 65535));
            in_last  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    // Called one step after the last beat's edge: the result must already be
    // valid. The task holds backpressure for `hold` cycles (with in_valid=busy),
    // then releases it.
    task automatic collect(input int hold, input logic busy);
        logic [40:0] e24;
        logic [40:0] e16;
        e24 = '0;
        e16 = '0;
        check("out_valid24_latency", {31'd0, out_valid24}, 32'd1);
        check("out_valid16_latency", {31'd0, out_valid16}, 32'd1);
        checks++;
        if (exp24_q.size() == 0 || exp16_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got result with no expected entry");
        end else begin
            e24 = exp24_q.pop_front();
            e16 = exp16_q.pop_front();
        end
        check("acc24", {8'd0, acc24}, e24[31:0]);
        check("cnt24", {24'd0, cnt24}, {24'd0, e24[39:32]});
        check("ovf24", {31'd0, ovf24}, {31'd0, e24[40]});
        check("acc16", {16'd0, acc16}, e16[31:0]);
        check("cnt16", {24'd0, cnt16}, {24'd0, e16[39:32]});
        check("ovf16", {31'd0, ovf16}, {31'd0, e16[40]});
        out_ready = 1'b0;
        for (int c = 0; c < hold; c++) begin
            in_valid = busy;
            product  = 16'($urandom_range(0, 65535));
            in_last  = 1'b1;
            @(posedge clk); #1;
            check("bp_in_ready24", {31'd0, in_ready24}, 32'd0);
            check("bp_out_valid24", {31'd0, out_valid24}, 32'd1);
            check("bp_acc24", {8'd0, acc24}, e24[31:0]);
            check("bp_cnt24", {24'd0, cnt24}, {24'd0, e24[39:32]});
            check("bp_acc16", {16'd0, acc16}, e16[31:0]);
            check("bp_ovf16", {31'd0, ovf16}, {31'd0, e16[40]});
        end
        // A beat offered in the release cycle must not be taken.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("release_out_valid24", {31'd0, out_valid24}, 32'd0);
        check("release_state24", {30'd0, st24}, 32'd0);
        check("idle_hold_acc24", {8'd0, acc24}, e24[31:0]);
        check("idle_hold_cnt24", {24'd0, cnt24}, {24'd0, e24[39:32]});
        check("idle_hold_acc16", {16'd0, acc16}, e16[31:0]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        product   = 16'h0;

        vecs[0] = '{beats: {16'h0, 16'h0, 16'h0, 16'hFE01}, n: 1,
                    acc24: 32'hFE01, acc16_wrap: 32'hFE01, acc16_sat: 32'hFE01,
                    cnt: 8'd1, ovf24: 1'b0, ovf16: 1'b0};
        vecs[1] = '{beats: {16'h1000, 16'h0100, 16'h0010, 16'h0001}, n: 4,
                    acc24: 32'h1111, acc16_wrap: 32'h1111, acc16_sat: 32'h1111,
                    cnt: 8'd4, ovf24: 1'b0, ovf16: 1'b0};
        vecs[2] = '{beats: {16'h0, 16'hFFFF, 16'hFFFF, 16'hFFFF}, n: 3,
                    acc24: 32'h2FFFD, acc16_wrap: 32'hFFFD, acc16_sat: 32'hFFFF,
                    cnt: 8'd3, ovf24: 1'b0, ovf16: 1'b1};
        vecs[3] = '{beats: {16'h0, 16'h0, 16'hFE01, 16'hFE01}, n: 2,
                    acc24: 32'h1FC02, acc16_wrap: 32'hFC02, acc16_sat: 32'hFFFF,
                    cnt: 8'd2, ovf24: 1'b0, ovf16: 1'b1};
        vecs[4] = '{beats: {16'h0, 16'h0, 16'h0, 16'h0005}, n: 1,
                    acc24: 32'h5, acc16_wrap: 32'h5, acc16_sat: 32'h5,
                    cnt: 8'd1, ovf24: 1'b0, ovf16: 1'b0};

        // Reset state is checked between clock edges.
        #3;
        check("rst_out_valid24", {31'd0, out_valid24}, 32'd0);
        check("rst_in_ready24", {31'd0, in_ready24}, 32'd1);
        check("rst_acc24", {8'd0, acc24}, 32'd0);
        check("rst_cnt24", {24'd0, cnt24}, 32'd0);
        check("rst_ovf24", {31'd0, ovf24}, 32'd0);
        check("rst_state16", {30'd0, st16}, 32'd0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven groups; group 1 also exercises 5 cycles of backpressure.
        for (int i = 0; i < 5; i++) begin
            push_exp(vecs[i].acc24, SAT ? vecs[i].acc16_sat : vecs[i].acc16_wrap,
                     vecs[i].cnt, vecs[i].ovf24, vecs[i].ovf16);
            for (int b = 0; b < vecs[i].n; b++) begin
                send_beat(vecs[i].beats[b], (b == vecs[i].n - 1));
            end
            collect((i == 1) ? 5 : 0, 1'b1);
            junk_cycles(2);
        end

        // Gaps carrying random bus values between the beats.
        push_exp(32'h123, 32'h123, 8'd3, 1'b0, 1'b0);
        send_beat(16'h0100, 1'b0);
        junk_cycles(3);
        send_beat(16'h0020, 1'b0);
        junk_cycles(2);
        send_beat(16'h0003, 1'b1);
        collect(0, 1'b0);

        // 257 beats of 0xFFFF: both widths overflow and beat_cnt wraps to 1.
        push_exp(SAT ? 32'hFFFFFF : 32'hFEFF, SAT ? 32'hFFFF : 32'hFEFF, 8'd1, 1'b1, 1'b1);
        for (int k = 0; k < 257; k++) begin
            send_beat(16'hFFFF, (k == 256));
        end
        collect(0, 1'b0);

        // Reset in the middle of a 3-beat group: the partial group is dropped.
        send_beat(16'h0011, 1'b0);
        send_beat(16'h0022, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid24", {31'd0, out_valid24}, 32'd0);
        check("midrst_acc24", {8'd0, acc24}, 32'd0);
        check("midrst_cnt16", {24'd0, cnt16}, 32'd0);
        check("midrst_in_ready24", {31'd0, in_ready24}, 32'd1);
        in_valid = 1'b1;
        product  = 16'h7777;
        in_last  = 1'b1;
        @(posedge clk); #1;
        check("rst_beat_ignored_acc24", {8'd0, acc24}, 32'd0);
        check("rst_beat_ignored_valid", {31'd0, out_valid24}, 32'd0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_out_valid24", {31'd0, out_valid24}, 32'd0);
        check("post_rst_out_valid16", {31'd0, out_valid16}, 32'd0);
        push_exp(32'h5, 32'h5, 8'd1, 1'b0, 1'b0);
        send_beat(16'h0005, 1'b1);
        collect(0, 1'b0);

        check("queue24_drained", exp24_q.size(), 32'd0);
        check("queue16_drained", exp16_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
